// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
//   shift_mode_e : 3-bit operation select (clear, load, shifts, rotates)
//   state_e      : controller state (idle / counted run)
//   is_left()    : true for modes whose shifted-out bit is the MSB
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_CLR  = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_LSR  = 3'b010,
        MODE_LSL  = 3'b011,
        MODE_ASR  = 3'b100,
        MODE_SRI  = 3'b101,
        MODE_ROR  = 3'b110,
        MODE_ROL  = 3'b111
    } shift_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_left(input shift_mode_e mode);
        return (mode == MODE_LSL) || (mode == MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One step of the universal shift register, purely combinational.
//   value       : current register contents
//   mode        : operation to apply
//   cin         : serial input, used by MODE_SRI only
//   load        : parallel load value, used by MODE_LOAD only
//   next_value  : register contents after the step
//   shifted_out : bit leaving the register (0 for clear/load)
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  shift_mode_e      mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] next_value,
    output logic             shifted_out
);

    always_comb begin
        next_value  = value;
        // Right-type modes expose the LSB, left-type modes the MSB.
        shifted_out = is_left(mode) ? value[WIDTH-1] : value[0];
        case (mode)
            MODE_CLR: begin
                next_value  = '0;
                shifted_out = 1'b0;
            end
            MODE_LOAD: begin
                next_value  = load;
                shifted_out = 1'b0;
            end
            MODE_LSR: next_value = {1'b0, value[WIDTH-1:1]};
            MODE_LSL: next_value = {value[WIDTH-2:0], 1'b0};
            MODE_ASR: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            MODE_SRI: next_value = {cin, value[WIDTH-1:1]};
            MODE_ROR: next_value = {value[0], value[WIDTH-1:1]};
            MODE_ROL: next_value = {value[WIDTH-2:0], value[WIDTH-1]};
            default:  next_value = value;
        endcase
    end

endmodule

// File: rtl/shift_register_n.sv
// Parametrised universal shift register with clock enable and a counted
// multi-step mode (start/busy/done handshake).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   en         : clock enable; when low register, sout and counter hold
//   start, cnt : request cnt steps of mode (sampled only when idle)
//   mode       : operation select (see shift_pkg::shift_mode_e)
//   cin        : serial input for MODE_SRI
//   load       : parallel load value
//   out        : register contents
//   sout       : bit most recently shifted out
//   busy       : counted operation in progress
//   done       : one-cycle pulse when a counted operation completes
module shift_register_n
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic             cin,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e             state_reg;
    shift_mode_e        mode_reg;
    logic [CNT_W-1:0]   remain_reg;
    logic [WIDTH-1:0]   out_reg;
    logic               sout_reg;
    logic               done_reg;

    shift_mode_e        step_mode;
    logic [WIDTH-1:0]   step_value;
    logic               step_sout;

    // A counted run uses the mode latched at start; live mode is ignored.
    always_comb begin
        step_mode = shift_mode_e'(mode);
        if (state_reg == ST_RUN) begin
            step_mode = mode_reg;
        end
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value      (out_reg),
        .mode       (step_mode),
        .cin        (cin),
        .load       (load),
        .next_value (step_value),
        .shifted_out(step_sout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= MODE_CLR;
            remain_reg <= '0;
            out_reg    <= '0;
            sout_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // start wins over a single step and is honoured even with en low.
                    if (start) begin
                        if (cnt != '0) begin
                            state_reg  <= ST_RUN;
                            mode_reg   <= shift_mode_e'(mode);
                            remain_reg <= cnt;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end else if (en) begin
                        out_reg  <= step_value;
                        sout_reg <= step_sout;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        out_reg    <= step_value;
                        sout_reg   <= step_sout;
                        remain_reg <= remain_reg - CNT_W'(1);
                        if (remain_reg == CNT_W'(1)) begin
                            state_reg <= ST_IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign out  = out_reg;
    assign sout = sout_reg;
    assign busy = (state_reg == ST_RUN);
    assign done = done_reg;

endmodule

// File: tb/tb_shift_register_n.sv
// Self-checking bench for shift_register_n: an 8-bit and a 16-bit instance
// share one clock. A behavioural model predicts every cycle; predictions are
// queued before each edge and popped/compared just after it.
module tb_shift_register_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       rst_n8, en8, start8, cin8;
    logic [2:0] mode8;
    logic [3:0] cnt8;
    logic [7:0] load8, out8;
    logic       sout8, busy8, done8;

    // 16-bit instance
    logic        rst_n16, en16, start16, cin16;
    logic [2:0]  mode16;
    logic [4:0]  cnt16;
    logic [15:0] load16, out16;
    logic        sout16, busy16, done16;

    shift_register_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .en(en8), .start(start8), .mode(mode8),
        .cnt(cnt8), .cin(cin8), .load(load8), .out(out8), .sout(sout8),
        .busy(busy8), .done(done8)
    );

    shift_register_n #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n16), .en(en16), .start(start16), .mode(mode16),
        .cnt(cnt16), .cin(cin16), .load(load16), .out(out16), .sout(sout16),
        .busy(busy16), .done(done16)
    );

    typedef struct {
        logic [15:0] val;
        logic        sout;
        logic        busy;
        logic        done;
        logic [2:0]  mode;
        int          rem;
    } model_t;

    model_t m8, m16;
    model_t sb8[$];
    model_t sb16[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int busy_cnt8, done_cnt8, busy_cnt16, done_cnt16;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic void step_ref(input logic [15:0] v, input int w, input logic [2:0] m,
                                     input logic c, input logic [15:0] ld,
                                     output logic [15:0] nv, output logic ns);
        logic [15:0] mask;
        logic        msb, lsb;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        msb  = v[w-1];
        lsb  = v[0];
        nv   = v;
        ns   = 1'b0;
        case (m)
            3'b000: nv = 16'h0;
            3'b001: nv = ld & mask;
            3'b010: begin nv = v >> 1;                                  ns = lsb; end
            3'b011: begin nv = (v << 1) & mask;                         ns = msb; end
            3'b100: begin nv = (v >> 1) | ({15'h0, msb} << (w - 1));    ns = lsb; end
            3'b101: begin nv = (v >> 1) | ({15'h0, c} << (w - 1));      ns = lsb; end
            3'b110: begin nv = (v >> 1) | ({15'h0, lsb} << (w - 1));    ns = lsb; end
            default: begin nv = ((v << 1) & mask) | {15'h0, msb};       ns = msb; end
        endcase
    endfunction

    function automatic model_t model_next(input model_t s, input logic rst_n, input logic en,
                                          input logic start, input logic [2:0] mode, input int cnt,
                                          input logic cin, input logic [15:0] ld, input int w);
        model_t      n;
        logic [15:0] nv;
        logic        ns;
        n = s;
        n.done = 1'b0;
        if (!rst_n) begin
            n = '{default: 0};
        end else if (s.busy) begin
            if (en) begin
                step_ref(s.val, w, s.mode, cin, ld, nv, ns);
                n.val  = nv;
                n.sout = ns;
                n.rem  = s.rem - 1;
                if (n.rem == 0) begin
                    n.busy = 1'b0;
                    n.done = 1'b1;
                end
            end
        end else if (start) begin
            if (cnt != 0) begin
                n.busy = 1'b1;
                n.mode = mode;
                n.rem  = cnt;
            end else begin
                n.done = 1'b1;
            end
        end else if (en) begin
            step_ref(s.val, w, mode, cin, ld, nv, ns);
            n.val  = nv;
            n.sout = ns;
        end
        return n;
    endfunction

    // One clock: predict, queue, clock, pop and compare both instances.
    task automatic tick();
        model_t e;
        m8  = model_next(m8, rst_n8, en8, start8, mode8, int'(cnt8), cin8, {8'h0, load8}, 8);
        m16 = model_next(m16, rst_n16, en16, start16, mode16, int'(cnt16), cin16, load16, 16);
        sb8.push_back(m8);
        sb16.push_back(m16);
        @(posedge clk);
        #1;
        cyc++;
        e = sb8.pop_front();
        check_val($sformatf("c%0d out8", cyc),  32'(out8),  32'(e.val));
        check_val($sformatf("c%0d sout8", cyc), 32'(sout8), 32'(e.sout));
        check_val($sformatf("c%0d busy8", cyc), 32'(busy8), 32'(e.busy));
        check_val($sformatf("c%0d done8", cyc), 32'(done8), 32'(e.done));
        e = sb16.pop_front();
        check_val($sformatf("c%0d out16", cyc),  32'(out16),  32'(e.val));
        check_val($sformatf("c%0d sout16", cyc), 32'(sout16), 32'(e.sout));
        check_val($sformatf("c%0d busy16", cyc), 32'(busy16), 32'(e.busy));
        check_val($sformatf("c%0d done16", cyc), 32'(done16), 32'(e.done));
        if (busy8)  busy_cnt8++;
        if (done8)  done_cnt8++;
        if (busy16) busy_cnt16++;
        if (done16) done_cnt16++;
        $display("cyc %0d: out8=%02h sout8=%0b busy8=%0b done8=%0b | out16=%04h busy16=%0b done16=%0b",
                 cyc, out8, sout8, busy8, done8, out16, busy16, done16);
    endtask

    task automatic drive8(input logic en, input logic start, input logic [2:0] mode,
                          input logic [3:0] cnt, input logic [7:0] load);
        en8 = en; start8 = start; mode8 = mode; cnt8 = cnt; load8 = load;
    endtask

    task automatic clear_counts();
        busy_cnt8 = 0; done_cnt8 = 0; busy_cnt16 = 0; done_cnt16 = 0;
    endtask

    initial begin
        rst_n8 = 1'b1; rst_n16 = 1'b1; cin8 = 1'b0; cin16 = 1'b0;
        drive8(1'b0, 1'b0, 3'b000, 4'd0, 8'h00);
        en16 = 1'b0; start16 = 1'b0; mode16 = 3'b000; cnt16 = 5'd0; load16 = 16'h0;
        m8 = '{default: 0};
        m16 = '{default: 0};
        clear_counts();

        // Asynchronous reset asserted mid-cycle takes effect before the next edge.
        #7;
        rst_n8 = 1'b0; rst_n16 = 1'b0;
        #1;
        check_val("rst_out8",  32'(out8),  32'h0);
        check_val("rst_busy8", 32'(busy8), 32'h0);
        check_val("rst_done8", 32'(done8), 32'h0);
        check_val("rst_out16", 32'(out16), 32'h0);
        tick();
        rst_n8 = 1'b1; rst_n16 = 1'b1;

        // Single steps.
        drive8(1'b1, 1'b0, 3'b001, 4'd0, 8'hB4); tick();
        check_val("ld_b4", 32'(out8), 32'hB4);
        drive8(1'b1, 1'b0, 3'b100, 4'd0, 8'h00); tick();
        check_val("asr_out", 32'(out8), 32'hDA);
        check_val("asr_sout", 32'(sout8), 32'h0);
        drive8(1'b1, 1'b0, 3'b010, 4'd0, 8'h00); tick();
        check_val("lsr_out", 32'(out8), 32'h6D);
        drive8(1'b1, 1'b0, 3'b111, 4'd0, 8'h00); tick();
        check_val("rol_out", 32'(out8), 32'hDA);
        check_val("rol_sout", 32'(sout8), 32'h0);
        drive8(1'b0, 1'b0, 3'b110, 4'd0, 8'h00); tick();
        check_val("en_hold", 32'(out8), 32'hDA);

        // Counted rotate right by 3; live mode/load changes must be ignored.
        drive8(1'b1, 1'b0, 3'b001, 4'd0, 8'h81); tick();
        clear_counts();
        drive8(1'b1, 1'b1, 3'b110, 4'd3, 8'h00); tick();
        check_val("ror_e0_out", 32'(out8), 32'h81);
        drive8(1'b1, 1'b0, 3'b000, 4'd0, 8'hFF); tick();
        check_val("ror_s1", 32'(out8), 32'hC0);
        tick();
        check_val("ror_s2", 32'(out8), 32'h60);
        tick();
        check_val("ror_s3", 32'(out8), 32'h30);
        check_val("ror_done", 32'(done8), 32'h1);
        check_val("ror_sout", 32'(sout8), 32'h0);
        drive8(1'b0, 1'b0, 3'b000, 4'd0, 8'h00); tick();
        check_val("ror_busy_cycles", 32'(busy_cnt8), 32'd3);
        check_val("ror_done_pulses", 32'(done_cnt8), 32'd1);

        // Counted shift left by 4 with a 2-cycle stall in the middle.
        drive8(1'b1, 1'b0, 3'b001, 4'd0, 8'h0F); tick();
        clear_counts();
        drive8(1'b1, 1'b1, 3'b011, 4'd4, 8'h00); tick();
        drive8(1'b1, 1'b0, 3'b011, 4'd0, 8'h00); tick(); tick();
        check_val("stall_pre", 32'(out8), 32'h3C);
        en8 = 1'b0; tick(); tick();
        check_val("stall_frozen", 32'(out8), 32'h3C);
        en8 = 1'b1; tick(); tick();
        check_val("stall_final", 32'(out8), 32'hF0);
        en8 = 1'b0; tick();
        check_val("stall_busy_cycles", 32'(busy_cnt8), 32'd6);
        check_val("stall_done_pulses", 32'(done_cnt8), 32'd1);

        // cnt=0 start: done pulse only, even with en low.
        clear_counts();
        drive8(1'b0, 1'b1, 3'b001, 4'd0, 8'hAA); tick();
        check_val("cnt0_done", 32'(done8), 32'h1);
        check_val("cnt0_out", 32'(out8), 32'hF0);
        drive8(1'b0, 1'b0, 3'b000, 4'd0, 8'h00); tick();
        check_val("cnt0_busy_cycles", 32'(busy_cnt8), 32'd0);

        // start with another mode while busy is ignored.
        drive8(1'b1, 1'b0, 3'b001, 4'd0, 8'h81); tick();
        clear_counts();
        drive8(1'b1, 1'b1, 3'b110, 4'd3, 8'h00); tick();
        drive8(1'b1, 1'b1, 3'b011, 4'd7, 8'h55); tick(); tick(); tick();
        check_val("restart_ignored", 32'(out8), 32'h30);
        drive8(1'b0, 1'b0, 3'b000, 4'd0, 8'h00); tick();
        check_val("restart_done_pulses", 32'(done_cnt8), 32'd1);

        // 16-bit: shift in sixteen 1s.
        clear_counts();
        cin16 = 1'b1; en16 = 1'b1; start16 = 1'b1; mode16 = 3'b101; cnt16 = 5'd16;
        tick();
        start16 = 1'b0; mode16 = 3'b000;
        for (int i = 0; i < 16; i++) tick();
        check_val("w16_full", 32'(out16), 32'hFFFF);
        check_val("w16_done", 32'(done16), 32'h1);
        en16 = 1'b0; tick();
        check_val("w16_busy_cycles", 32'(busy_cnt16), 32'd16);

        // Same run aborted by reset after step 5.
        en16 = 1'b1; mode16 = 3'b000; tick();
        clear_counts();
        start16 = 1'b1; mode16 = 3'b101; cnt16 = 5'd16; tick();
        start16 = 1'b0; mode16 = 3'b000;
        for (int i = 0; i < 5; i++) tick();
        check_val("w16_step5", 32'(out16), 32'hF800);
        #3;
        rst_n16 = 1'b0;
        m16 = '{default: 0};
        #1;
        check_val("w16_rst_out", 32'(out16), 32'h0);
        check_val("w16_rst_busy", 32'(busy16), 32'h0);
        check_val("w16_rst_done", 32'(done16), 32'h0);
        tick();
        rst_n16 = 1'b1; en16 = 1'b0;
        tick(); tick();
        check_val("w16_no_done", 32'(done_cnt16), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
